// File: rtl/match_game_ctrl.sv
// Round sequencer for the switch-matching game: owns the level, shows the
// target pattern on LEDR, runs a BCD seconds timer and decides WIN/FAIL.
// Every output comes straight from a register; registered outputs are
// computed from the next state so they line up with the state register.
module match_game_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int TIME_LIMIT  = 30,
  parameter int NUM_LEVELS  = 4,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [13:0] sw,
  output logic [13:0] pattern_led,
  output logic        go_led,
  output logic [1:0]  level,
  output logic [3:0]  secs_ones,
  output logic [3:0]  secs_tens,
  output logic [2:0]  state,
  output logic        win,
  output logic        fail
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_PLAY  = 3'd2,
    S_CLEAR = 3'd3,
    S_WIN   = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] hold_q, hold_d;
  logic [13:0] pattern_q, pattern_d;
  logic        go_q, go_d;
  logic        win_q, win_d;
  logic        fail_q, fail_d;

  logic        match;
  logic        hold_done;
  logic        timeout;
  logic [6:0]  secs_val;

  // Target pattern per level.
  function automatic logic [13:0] pattern_of(input logic [1:0] lv);
    logic [13:0] p;
    case (lv)
      2'd0:    p = 14'h0011;
      2'd1:    p = 14'h0C30;
      2'd2:    p = 14'h2A55;
      default: p = 14'h3FFF;
    endcase
    return p;
  endfunction

  // Next-state, timer, hold counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    presc_d   = presc_q;
    hold_d    = hold_q;
    pattern_d = 14'h0000;
    go_d      = 1'b0;
    win_d     = 1'b0;
    fail_d    = 1'b0;

    match     = (sw == pattern_of(level_q));
    hold_done = match && (hold_q == 16'(HOLD_CYCLES - 1));
    secs_val  = 7'(tens_q) * 7'd10 + 7'(ones_q);
    timeout   = (secs_val == 7'(TIME_LIMIT));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          level_d = 2'd0;
        end
      end
      S_ARM: begin
        // Wait for all switches down so a leftover match cannot fire instantly.
        if (sw == 14'h0000) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (!pause) begin
          if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        // The hold counter ignores pause: a held match still completes.
        hold_d = match ? hold_q + 16'd1 : 16'd0;
        // A completing match beats a same-cycle timeout.
        if (hold_done)    state_d = S_CLEAR;
        else if (timeout) state_d = S_FAIL;
      end
      S_CLEAR: begin
        if (level_q == 2'(NUM_LEVELS - 1)) begin
          state_d = S_WIN;
        end else begin
          level_d = level_q + 2'd1;
          state_d = S_ARM;
        end
      end
      S_WIN, S_FAIL: begin
        if (start) begin
          state_d = S_ARM;
          level_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Anything entering or sitting in ARM starts the level from a clean timer.
    if (state_d == S_ARM) begin
      presc_d = '0;
      hold_d  = 16'd0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
    end

    case (state_d)
      S_ARM:   pattern_d = pattern_of(level_d);
      S_PLAY:  pattern_d = pattern_of(level_d) & ~sw;
      S_WIN:   pattern_d = 14'h3FFF;
      default: pattern_d = 14'h0000;
    endcase
    go_d   = (state_d == S_PLAY);
    win_d  = (state_d == S_WIN);
    fail_d = (state_d == S_FAIL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      level_q   <= 2'd0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      presc_q   <= '0;
      hold_q    <= 16'd0;
      pattern_q <= 14'h0000;
      go_q      <= 1'b0;
      win_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      pattern_q <= pattern_d;
      go_q      <= go_d;
      win_q     <= win_d;
      fail_q    <= fail_d;
    end
  end

  assign pattern_led = pattern_q;
  assign go_led      = go_q;
  assign level       = level_q;
  assign secs_ones   = ones_q;
  assign secs_tens   = tens_q;
  assign state       = state_q;
  assign win         = win_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_match_game_ctrl.sv
// Directed bench for match_game_ctrl with a small, fast configuration.
// Each snapshot packs {state, level, tens, ones, go, win, fail, pattern}.
module tb_match_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pause;
  logic [13:0] sw;
  logic [13:0] pattern_led;
  logic        go_led;
  logic [1:0]  level;
  logic [3:0]  secs_ones;
  logic [3:0]  secs_tens;
  logic [2:0]  state;
  logic        win;
  logic        fail;

  int checks = 0;
  int failures = 0;
  logic [29:0] obs;
  logic [29:0] exp_v;

  match_game_ctrl #(
    .TICK_DIV(4), .TIME_LIMIT(3), .NUM_LEVELS(2), .HOLD_CYCLES(2)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .pause(pause), .sw(sw),
    .pattern_led(pattern_led), .go_led(go_led), .level(level),
    .secs_ones(secs_ones), .secs_tens(secs_tens), .state(state),
    .win(win), .fail(fail)
  );

  // Clock
  always #5 clk = ~clk;

  assign obs = {state, level, secs_tens, secs_ones, go_led, win, fail, pattern_led};

  function automatic logic [29:0] snap(input logic [2:0] st, input logic [1:0] lv,
                                       input logic [3:0] t, input logic [3:0] o,
                                       input logic g, input logic w, input logic f,
                                       input logic [13:0] p);
    return {st, lv, t, o, g, w, f, p};
  endfunction

  // Advance n clock edges; inputs settle and outputs are sampled 1 ns after.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; sw = 14'h0000;
    step(2);
    reset = 1'b0;
    exp_v = snap(3'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
    step(1);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL idle_hold: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_start();
    start = 1'b1; step(1); start = 1'b0;
    exp_v = snap(3'd1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 14'h0011);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL start_arm: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd2, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0011);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL arm_to_play: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_match();
    sw = 14'h0001; step(1);
    exp_v = snap(3'd2, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0010);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL partial_sw: got %h want %h", obs, exp_v); end
    sw = 14'h0011; step(1);
    exp_v = snap(3'd2, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL match_first_cycle: got %h want %h", obs, exp_v); end
    sw = 14'h0001; step(1);
    sw = 14'h0011; step(1);
    exp_v = snap(3'd2, 2'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL hold_restart: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd3, 2'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL clear_l0: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd1, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL arm_l1: got %h want %h", obs, exp_v); end
    step(1);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL arm_wait_sw: got %h want %h", obs, exp_v); end
    sw = 14'h0000; step(1);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL play_l1: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_timeout();
    step(3);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL pre_tick: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL tick1: got %h want %h", obs, exp_v); end
    step(4);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL tick2: got %h want %h", obs, exp_v); end
    step(4);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL tick3: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd5, 2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL timeout_fail: got %h want %h", obs, exp_v); end
    sw = 14'h3FFF; step(1);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL fail_sticky: got %h want %h", obs, exp_v); end
    start = 1'b1; step(1); start = 1'b0;
    exp_v = snap(3'd1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 14'h0011);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL restart_from_fail: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_pause();
    sw = 14'h0000; step(1);
    step(2);
    pause = 1'b1; step(20);
    exp_v = snap(3'd2, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0011);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL pause_freeze: got %h want %h", obs, exp_v); end
    pause = 1'b0; step(1);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL pause_resume_pre: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd2, 2'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 14'h0011);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL pause_resume_tick: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_win();
    sw = 14'h0011; step(2);
    exp_v = snap(3'd3, 2'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL clear_frozen: got %h want %h", obs, exp_v); end
    sw = 14'h0000; step(2);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL play_l1_again: got %h want %h", obs, exp_v); end
    step(11);
    sw = 14'h0C30; step(1);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL limit_reached: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd3, 2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL match_beats_timeout: got %h want %h", obs, exp_v); end
    step(1);
    exp_v = snap(3'd4, 2'd1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 14'h3FFF);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL win_state: got %h want %h", obs, exp_v); end
    sw = 14'h0000; step(1);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL win_sticky: got %h want %h", obs, exp_v); end
    start = 1'b1; step(1); start = 1'b0;
    exp_v = snap(3'd1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 14'h0011);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL restart_from_win: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    step(1);
    sw = 14'h0011; step(2);
    exp_v = snap(3'd3, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL clear_fast: got %h want %h", obs, exp_v); end
    sw = 14'h0000; step(2);
    start = 1'b1; step(1); start = 1'b0;
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL start_ignored_play: got %h want %h", obs, exp_v); end
    step(7);
    exp_v = snap(3'd2, 2'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 14'h0C30);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL secs_two: got %h want %h", obs, exp_v); end
    reset = 1'b1; start = 1'b1; step(1);
    reset = 1'b0; start = 1'b0;
    exp_v = snap(3'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 14'h0000);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_mid_game: got %h want %h", obs, exp_v); end
    step(1);
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL idle_after_reset: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; sw = 14'h0000;
    test_reset();
    test_start();
    test_match();
    test_timeout();
    test_pause();
    test_win();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
